// File: rtl/md4_pkg.sv
// md4_pkg: MD4 constants, per-round lookup tables, round functions and the
// shared types used by the iterative compression core.
package md4_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIN,
    DONE
  } state_e;

  // One MD4 working/chaining state; packs to {A,B,C,D} with A in the MSBs.
  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic [31:0] d;
  } md4_words_t;

  localparam int STEPS = 48;

  localparam logic [31:0] IV_A = 32'h67452301;
  localparam logic [31:0] IV_B = 32'hefcdab89;
  localparam logic [31:0] IV_C = 32'h98badcfe;
  localparam logic [31:0] IV_D = 32'h10325476;
  localparam md4_words_t  IV   = '{a: IV_A, b: IV_B, c: IV_C, d: IV_D};

  localparam logic [31:0] K_R0 = 32'h00000000;
  localparam logic [31:0] K_R1 = 32'h5a827999;
  localparam logic [31:0] K_R2 = 32'h6ed9eba1;

  localparam logic [4:0] S_R0 [4] = '{5'd3, 5'd7, 5'd11, 5'd19};
  localparam logic [4:0] S_R1 [4] = '{5'd3, 5'd5, 5'd9, 5'd13};
  localparam logic [4:0] S_R2 [4] = '{5'd3, 5'd9, 5'd11, 5'd15};

  localparam logic [3:0] IDX_R1 [16] = '{4'd0, 4'd4, 4'd8, 4'd12, 4'd1, 4'd5, 4'd9, 4'd13,
                                         4'd2, 4'd6, 4'd10, 4'd14, 4'd3, 4'd7, 4'd11, 4'd15};
  localparam logic [3:0] IDX_R2 [16] = '{4'd0, 4'd8, 4'd4, 4'd12, 4'd2, 4'd10, 4'd6, 4'd14,
                                         4'd1, 4'd9, 4'd5, 4'd13, 4'd3, 4'd11, 4'd7, 4'd15};

  function automatic logic [31:0] md4_f(input logic [31:0] x, input logic [31:0] y,
                                        input logic [31:0] z);
    return (x & y) | (~x & z);
  endfunction

  function automatic logic [31:0] md4_g(input logic [31:0] x, input logic [31:0] y,
                                        input logic [31:0] z);
    return (x & y) | (x & z) | (y & z);
  endfunction

  function automatic logic [31:0] md4_h(input logic [31:0] x, input logic [31:0] y,
                                        input logic [31:0] z);
    return x ^ y ^ z;
  endfunction

  // Round function selected by round number.
  function automatic logic [31:0] md4_fn(input logic [1:0] r, input logic [31:0] x,
                                         input logic [31:0] y, input logic [31:0] z);
    case (r)
      2'd0:    return md4_f(x, y, z);
      2'd1:    return md4_g(x, y, z);
      default: return md4_h(x, y, z);
    endcase
  endfunction

  function automatic logic [31:0] md4_k(input logic [1:0] r);
    case (r)
      2'd0:    return K_R0;
      2'd1:    return K_R1;
      default: return K_R2;
    endcase
  endfunction

  // Rotate amount for round r, step position j = i%4.
  function automatic logic [4:0] md4_s(input logic [1:0] r, input logic [1:0] j);
    case (r)
      2'd0:    return S_R0[j];
      2'd1:    return S_R1[j];
      default: return S_R2[j];
    endcase
  endfunction

  // Message word consumed by step i of round r.
  function automatic logic [3:0] md4_msg_idx(input logic [1:0] r, input logic [3:0] i);
    case (r)
      2'd0:    return i;
      2'd1:    return IDX_R1[i];
      default: return IDX_R2[i];
    endcase
  endfunction

  function automatic logic [31:0] md4_rotl(input logic [31:0] x, input logic [4:0] s);
    logic [5:0] rs;
    rs = 6'd32 - {1'b0, s};
    return (x << s) | (x >> rs);
  endfunction

endpackage

// File: rtl/md4_iter_core_if.sv
// md4_iter_core_if: block input and digest output handshakes of the MD4 core.
interface md4_iter_core_if;
  logic         in_valid;
  logic         in_ready;
  logic [511:0] in_block;
  logic         in_first;
  logic         in_last;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] digest;

  // Upstream padder plus downstream digest consumer.
  modport master (
    output in_valid, in_block, in_first, in_last, out_ready,
    input  in_ready, out_valid, digest
  );

  // The compression core.
  modport slave (
    input  in_valid, in_block, in_first, in_last, out_ready,
    output in_ready, out_valid, digest
  );
endinterface

// File: rtl/md4_step.sv
// md4_step: one combinational MD4 step. Updates the word at the rotating
// 'a' position and rotates the working registers to {d, a_new, b, c}.
module md4_step
  import md4_pkg::*;
(
  input  md4_words_t  st_i,
  input  logic [31:0] m_i,
  input  logic [1:0]  round_i,
  input  logic [1:0]  shift_sel_i,  // i % 4 within the round
  output md4_words_t  st_o
);

  logic [31:0] t;

  // Step arithmetic: add, rotate, then rotate register roles.
  always_comb begin
    t    = st_i.a + md4_fn(round_i, st_i.b, st_i.c, st_i.d) + m_i + md4_k(round_i);
    st_o = '{a: st_i.d, b: md4_rotl(t, md4_s(round_i, shift_sel_i)), c: st_i.b, d: st_i.c};
  end

endmodule

// File: rtl/md4_iter_core.sv
// md4_iter_core: iterative multi-block MD4 compression. One 512-bit block is
// compressed in 48/ROUNDS_PER_CYCLE RUN cycles plus one FIN cycle; the chain
// persists across blocks and the digest is presented on the last block.
module md4_iter_core
  import md4_pkg::*;
#(
  parameter int ROUNDS_PER_CYCLE = 1
) (
  input  logic            clk,
  input  logic            rst,
  md4_iter_core_if.slave  bus
);

  if (ROUNDS_PER_CYCLE != 1 && ROUNDS_PER_CYCLE != 2 && ROUNDS_PER_CYCLE != 4 &&
      ROUNDS_PER_CYCLE != 8 && ROUNDS_PER_CYCLE != 16) begin : g_bad_rpc
    $error("md4_iter_core: ROUNDS_PER_CYCLE must be 1, 2, 4, 8 or 16");
  end

  localparam logic [5:0] RPC_W      = 6'(ROUNDS_PER_CYCLE);
  localparam logic [5:0] LAST_GROUP = 6'(STEPS - ROUNDS_PER_CYCLE);

  state_e             state_q, state_d;
  logic [5:0]         step_q, step_d;
  md4_words_t         work_q, work_d;
  md4_words_t         chain_q, chain_d;
  logic [127:0]       digest_q, digest_d;
  logic [15:0][31:0]  blk_q, blk_d;
  logic               last_q, last_d;
  md4_words_t         step_out;

  // Chain of step instances; a group never straddles a round because
  // ROUNDS_PER_CYCLE divides 16, so every instance sees the same round.
  for (genvar g = 0; g < ROUNDS_PER_CYCLE; g++) begin : g_step
    md4_words_t st_in;
    md4_words_t st_out;
    logic [5:0] s_idx;

    if (g == 0) begin : g_head
      assign st_in = work_q;
    end else begin : g_link
      assign st_in = g_step[g-1].st_out;
    end

    assign s_idx = step_q + 6'(g);

    md4_step u_step (
      .st_i        (st_in),
      .m_i         (blk_q[md4_msg_idx(s_idx[5:4], s_idx[3:0])]),
      .round_i     (s_idx[5:4]),
      .shift_sel_i (s_idx[1:0]),
      .st_o        (st_out)
    );
  end

  assign step_out = g_step[ROUNDS_PER_CYCLE-1].st_out;

  // Next-state and datapath control for the IDLE/RUN/FIN/DONE sequence.
  always_comb begin
    // NOTE: every variable gets a hold default first so no branch can infer a latch.
    state_d  = state_q;
    step_d   = step_q;
    work_d   = work_q;
    chain_d  = chain_q;
    digest_d = digest_q;
    blk_d    = blk_q;
    last_d   = last_q;

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          blk_d   = bus.in_block;
          last_d  = bus.in_last;
          work_d  = bus.in_first ? IV : chain_q;
          chain_d = work_d;
          step_d  = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        work_d = step_out;
        if (step_q == LAST_GROUP) begin
          step_d  = '0;
          state_d = FIN;
        end else begin
          step_d = step_q + RPC_W;
        end
      end
      FIN: begin
        chain_d.a = chain_q.a + work_q.a;
        chain_d.b = chain_q.b + work_q.b;
        chain_d.c = chain_q.c + work_q.c;
        chain_d.d = chain_q.d + work_q.d;
        if (last_q) begin
          digest_d = chain_d;
          state_d  = DONE;
        end else begin
          state_d = IDLE;
        end
      end
      DONE: begin
        // Consumption returns to IDLE; a block can only be taken next cycle.
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control, working and chaining registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register updates from pre-edge values.
    if (rst) begin
      state_q  <= IDLE;
      step_q   <= '0;
      work_q   <= '0;
      chain_q  <= IV;
      digest_q <= '0;
    end else begin
      state_q  <= state_d;
      step_q   <= step_d;
      work_q   <= work_d;
      chain_q  <= chain_d;
      digest_q <= digest_d;
    end
  end

  // Latched message block and last flag.
  always_ff @(posedge clk) begin
    // NOTE: no reset on these data-only registers; they are always loaded on
    // acceptance before RUN/FIN read them.
    blk_q  <= blk_d;
    last_q <= last_d;
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.digest    = digest_q;

endmodule

// File: tb/tb_md4_iter_core.sv
// tb_md4_iter_core: drives three core builds (1, 4 and 16 steps per cycle)
// and checks digests and timing against a software-style MD4 model.
module tb_md4_iter_core;

  localparam int N_DUT = 3;

  localparam logic [127:0] TB_IV = 128'h67452301_efcdab89_98badcfe_10325476;
  localparam logic [127:0] V1    = 128'he0cfd631_31e96ad1_d7593cb7_c089c0e0;
  localparam logic [127:0] V2    = 128'h7a0148a4_52d821af_e80ac15f_9d72a67a;

  localparam int ORDER [3][16] = '{
    '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15},
    '{0, 4, 8, 12, 1, 5, 9, 13, 2, 6, 10, 14, 3, 7, 11, 15},
    '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15}
  };
  localparam int SHIFT [3][4] = '{'{3, 7, 11, 19}, '{3, 5, 9, 13}, '{3, 9, 11, 15}};
  localparam logic [31:0] KC [3] = '{32'h00000000, 32'h5a827999, 32'h6ed9eba1};

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         in_valid  [N_DUT];
  logic [511:0] in_block  [N_DUT];
  logic         in_first  [N_DUT];
  logic         in_last   [N_DUT];
  logic         out_ready [N_DUT];
  logic         in_ready  [N_DUT];
  logic         out_valid [N_DUT];
  logic [127:0] digest    [N_DUT];

  logic [127:0] model_chain [N_DUT];
  int n_tests;
  int n_fail;

  for (genvar g = 0; g < N_DUT; g++) begin : g_dut
    localparam int RPC = (g == 0) ? 1 : ((g == 1) ? 4 : 16);
    md4_iter_core_if bus ();
    assign bus.in_valid  = in_valid[g];
    assign bus.in_block  = in_block[g];
    assign bus.in_first  = in_first[g];
    assign bus.in_last   = in_last[g];
    assign bus.out_ready = out_ready[g];
    assign in_ready[g]   = bus.in_ready;
    assign out_valid[g]  = bus.out_valid;
    assign digest[g]     = bus.digest;

    md4_iter_core #(.ROUNDS_PER_CYCLE(RPC)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
    );
  end

  function automatic int rpc_of(input int k);
    case (k)
      0:       return 1;
      1:       return 4;
      default: return 16;
    endcase
  endfunction

  // RFC-style MD4 compression: four named registers updated in place with
  // the target register cycling a, d, c, b.
  function automatic logic [127:0] ref_compress(input logic [127:0] chain,
                                                input logic [511:0] blk);
    logic [31:0] x [16];
    logic [31:0] v [4];
    logic [31:0] f;
    logic [31:0] sum;
    int t;
    int sh;
    for (int j = 0; j < 16; j++) x[j] = blk[32*j +: 32];
    v[0] = chain[127:96];
    v[1] = chain[95:64];
    v[2] = chain[63:32];
    v[3] = chain[31:0];
    for (int r = 0; r < 3; r++) begin
      for (int j = 0; j < 16; j++) begin
        t = (4 - (j % 4)) % 4;
        if (r == 0)
          f = (v[(t+1)%4] & v[(t+2)%4]) | (~v[(t+1)%4] & v[(t+3)%4]);
        else if (r == 1)
          f = (v[(t+1)%4] & v[(t+2)%4]) | (v[(t+1)%4] & v[(t+3)%4]) |
              (v[(t+2)%4] & v[(t+3)%4]);
        else
          f = v[(t+1)%4] ^ v[(t+2)%4] ^ v[(t+3)%4];
        sum  = v[t] + f + x[ORDER[r][j]] + KC[r];
        sh   = SHIFT[r][j % 4];
        v[t] = (sum << sh) | (sum >> (32 - sh));
      end
    end
    return {chain[127:96] + v[0], chain[95:64] + v[1], chain[63:32] + v[2], chain[31:0] + v[3]};
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one block to core k, follow it to completion and check timing,
  // digest and (for last blocks) the DONE hold/consume behaviour.
  task automatic process_block(input int k, input logic [511:0] blk, input bit first,
                               input bit last, input int hold, input bit poke,
                               input string tag);
    int lat;
    int exp_lat;
    exp_lat = 48 / rpc_of(k) + 1;
    out_ready[k] = (hold == 0);

    lat = 0;
    while (!in_ready[k] && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_in_ready"}, 128'(in_ready[k]), 128'(1));

    in_valid[k] = 1'b1;
    in_block[k] = blk;
    in_first[k] = first;
    in_last[k]  = last;
    @(posedge clk); #1;
    in_valid[k] = 1'b0;
    in_block[k] = {16{$urandom()}};
    in_first[k] = 1'($urandom_range(1));
    in_last[k]  = 1'($urandom_range(1));

    if (first) model_chain[k] = TB_IV;
    model_chain[k] = ref_compress(model_chain[k], blk);

    lat = 0;
    while (!out_valid[k] && !in_ready[k] && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_latency"}, 128'(lat), 128'(exp_lat));
    check({tag, "_out_valid"}, 128'(out_valid[k]), 128'(last));

    if (last) begin
      check({tag, "_digest"}, digest[k], model_chain[k]);
      for (int h = 0; h < hold; h++) begin
        if (poke) begin
          in_valid[k] = 1'b1;
          in_block[k] = {16{$urandom()}};
          in_first[k] = 1'b1;
          in_last[k]  = 1'b1;
        end
        @(posedge clk); #1;
        check({tag, "_hold_valid"}, 128'(out_valid[k]), 128'(1));
        check({tag, "_hold_digest"}, digest[k], model_chain[k]);
        check({tag, "_hold_in_ready"}, 128'(in_ready[k]), 128'(0));
      end
      out_ready[k] = 1'b1;
      @(posedge clk); #1;
      check({tag, "_consumed_valid"}, 128'(out_valid[k]), 128'(0));
      check({tag, "_consumed_in_ready"}, 128'(in_ready[k]), 128'(1));
      check({tag, "_digest_kept"}, digest[k], model_chain[k]);
      in_valid[k] = 1'b0;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [511:0] v1_blk;
    logic [511:0] v2_blk;
    logic [511:0] aa_blk;
    logic [511:0] pad_blk;
    logic [511:0] rnd_blk;
    bit seen;
    int nb;
    bit first;
    bit last;

    n_tests = 0;
    n_fail  = 0;
    rst     = 1'b1;
    for (int k = 0; k < N_DUT; k++) begin
      in_valid[k]    = 1'b0;
      in_block[k]    = '0;
      in_first[k]    = 1'b0;
      in_last[k]     = 1'b0;
      out_ready[k]   = 1'b1;
      model_chain[k] = TB_IV;
    end

    v1_blk = '0;
    v1_blk[31:0] = 32'h00000080;
    v2_blk = '0;
    v2_blk[31:0] = 32'h80636261;
    v2_blk[14*32 +: 32] = 32'h00000018;
    aa_blk = {16{32'h61616161}};
    pad_blk = '0;
    pad_blk[31:0] = 32'h00000080;
    pad_blk[14*32 +: 32] = 32'h00000200;

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Reset state of every build.
    for (int k = 0; k < N_DUT; k++) begin
      check($sformatf("reset_in_ready_%0d", k), 128'(in_ready[k]), 128'(1));
      check($sformatf("reset_out_valid_%0d", k), 128'(out_valid[k]), 128'(0));
      check($sformatf("reset_digest_%0d", k), digest[k], 128'(0));
    end

    // Empty message and "abc" on every build.
    for (int k = 0; k < N_DUT; k++) begin
      process_block(k, v1_blk, 1'b1, 1'b1, 0, 1'b0, $sformatf("v1_rpc%0d", rpc_of(k)));
      check($sformatf("v1_const_rpc%0d", rpc_of(k)), digest[k], V1);
      process_block(k, v2_blk, 1'b1, 1'b1, 0, 1'b0, $sformatf("v2_rpc%0d", rpc_of(k)));
      check($sformatf("v2_const_rpc%0d", rpc_of(k)), digest[k], V2);
    end

    // Two-block message: 64 'a' bytes then the padding block.
    process_block(0, aa_blk, 1'b1, 1'b0, 0, 1'b0, "two_blk_1");
    process_block(0, pad_blk, 1'b0, 1'b1, 0, 1'b0, "two_blk_2");

    // Backpressure: ten stalled cycles with a competing block offered.
    process_block(0, v2_blk, 1'b1, 1'b1, 10, 1'b1, "backpressure");

    // Abort at step 20 after the chain has moved away from IV.
    process_block(0, aa_blk, 1'b1, 1'b0, 0, 1'b0, "abort_pre");
    in_valid[0] = 1'b1;
    in_block[0] = {16{$urandom()}};
    in_first[0] = 1'b0;
    in_last[0]  = 1'b1;
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < N_DUT; k++) model_chain[k] = TB_IV;
    check("abort_in_ready", 128'(in_ready[0]), 128'(1));
    check("abort_out_valid", 128'(out_valid[0]), 128'(0));
    check("abort_digest", digest[0], 128'(0));
    seen = 1'b0;
    repeat (60) begin
      @(posedge clk); #1;
      if (out_valid[0]) seen = 1'b1;
    end
    check("abort_no_out_valid", 128'(seen), 128'(0));
    process_block(0, v2_blk, 1'b0, 1'b1, 0, 1'b0, "abort_abc");
    check("abort_abc_const", digest[0], V2);

    // Randomised multi-block messages with random backpressure.
    for (int k = 0; k < N_DUT; k++) begin
      for (int m = 0; m < 4; m++) begin
        nb = int'($urandom_range(1, 3));
        for (int b = 0; b < nb; b++) begin
          rnd_blk = {16{$urandom()}};
          for (int w = 0; w < 16; w++) rnd_blk[32*w +: 32] = $urandom();
          first = (b == 0) ? ($urandom_range(3) != 0) : 1'b0;
          last  = (b == nb - 1);
          process_block(k, rnd_blk, first, last, last ? int'($urandom_range(3)) : 0, 1'b0,
                        $sformatf("rand_rpc%0d_m%0d_b%0d", rpc_of(k), m, b));
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
